// File: rtl/jk_flip_flop_if.sv
// rtl/jk_flip_flop_if.sv - JK flop bank signal bundle
// Master drives the J/K commands and observes q/qn; slave is the flop bank.
interface jk_flip_flop_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;

  modport master (
    output j,
    output k,
    input  q,
    input  qn
  );

  modport slave (
    input  j,
    input  k,
    output q,
    output qn
  );
endinterface

// File: rtl/jk_flip_flop.sv
// rtl/jk_flip_flop.sv - positive-edge JK flip-flop bank, async active-high reset
// Each bit is an independent JK flop; qn is the combinational complement of q.
module jk_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic           clk,
  input  logic           rst,
  jk_flip_flop_if.slave  bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Covers hold/reset/set/toggle per bit in one bitwise equation.
  always_comb begin
    q_d = (bus.j & ~q_q) | (~bus.k & q_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.q  = q_q;
  assign bus.qn = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// tb/tb_jk_flip_flop.sv - directed self-checking bench for jk_flip_flop
module tb_jk_flip_flop;

  typedef struct {
    logic j;
    logic k;
    logic q;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  jk_flip_flop_if #(.WIDTH(1)) bus1 ();
  jk_flip_flop_if #(.WIDTH(4)) bus4 ();

  jk_flip_flop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  jk_flip_flop #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    tests  = 0;
    failed = 0;

    vecs[0]  = '{j: 1'b1, k: 1'b0, q: 1'b1};
    vecs[1]  = '{j: 1'b0, k: 1'b1, q: 1'b0};
    vecs[2]  = '{j: 1'b1, k: 1'b0, q: 1'b1};
    vecs[3]  = '{j: 1'b0, k: 1'b0, q: 1'b1};
    vecs[4]  = '{j: 1'b0, k: 1'b0, q: 1'b1};
    vecs[5]  = '{j: 1'b0, k: 1'b0, q: 1'b1};
    vecs[6]  = '{j: 1'b0, k: 1'b1, q: 1'b0};
    vecs[7]  = '{j: 1'b0, k: 1'b0, q: 1'b0};
    vecs[8]  = '{j: 1'b0, k: 1'b0, q: 1'b0};
    vecs[9]  = '{j: 1'b0, k: 1'b0, q: 1'b0};
    vecs[10] = '{j: 1'b1, k: 1'b0, q: 1'b1};
    vecs[11] = '{j: 1'b1, k: 1'b1, q: 1'b0};
    vecs[12] = '{j: 1'b1, k: 1'b1, q: 1'b1};
    vecs[13] = '{j: 1'b1, k: 1'b1, q: 1'b0};

    rst    = 1'b1;
    bus1.j = 1'b1;
    bus1.k = 1'b0;
    bus4.j = 4'b0000;
    bus4.k = 4'b0000;

    #2;
    check("reset_q", {3'b0, bus1.q}, 4'b0000);
    check("reset_qn", {3'b0, bus1.qn}, 4'b0001);
    check("reset_q4", bus4.q, 4'b1010);
    check("reset_qn4", bus4.qn, 4'b0101);

    edge_wait();
    check("reset_held_edge", {3'b0, bus1.q}, 4'b0000);

    rst = 1'b0;
    #1;
    check("release_before_edge", {3'b0, bus1.q}, 4'b0000);

    for (int i = 0; i < 14; i++) begin
      bus1.j = vecs[i].j;
      bus1.k = vecs[i].k;
      edge_wait();
      check($sformatf("vec%0d_q", i), {3'b0, bus1.q}, {3'b0, vecs[i].q});
      check($sformatf("vec%0d_qn", i), {3'b0, bus1.qn}, {3'b0, ~vecs[i].q});
    end

    // Reset asserted between edges while toggling.
    bus1.j = 1'b1;
    bus1.k = 1'b1;
    edge_wait();
    check("toggle_before_rst", {3'b0, bus1.q}, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_toggle_q", {3'b0, bus1.q}, 4'b0000);
    check("rst_mid_toggle_qn", {3'b0, bus1.qn}, 4'b0001);
    edge_wait();
    check("rst_over_edge", {3'b0, bus1.q}, 4'b0000);
    rst = 1'b0;
    #1;
    edge_wait();
    check("toggle_after_release", {3'b0, bus1.q}, 4'b0001);

    check("w4_after_reset", bus4.q, 4'b1010);
    bus4.j = 4'b0011;
    bus4.k = 4'b0101;
    edge_wait();
    check("w4_mixed_q", bus4.q, 4'b1011);
    check("w4_mixed_qn", bus4.qn, 4'b0100);
    bus4.j = 4'b1111;
    bus4.k = 4'b1111;
    edge_wait();
    check("w4_toggle_all", bus4.q, 4'b0100);
    bus4.j = 4'b1000;
    bus4.k = 4'b0101;
    edge_wait();
    check("w4_set_reset_hold", bus4.q, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/jk_flip_flop.md
Name: jk_flip_flop

Overview:
Positive-edge-triggered JK flip-flop bank with asynchronous active-high reset. It is a general sequential primitive for counters, toggle controls and small state elements. It is parameterized in width, and each bit is an independent JK flop sharing one clock and reset. The default WIDTH=1 gives a single classic JK flip-flop.

Parameters:
WIDTH, 1, number of independent JK flop bits (legal range 1 or more).
RESET_VALUE, {WIDTH{1'b0}}, value loaded into q when rst is asserted.

Ports:
clk  input  1  clock; all state changes except reset occur on its rising edge.
rst  input  1  reset; asynchronous, active-high; forces q to RESET_VALUE.
j  input  WIDTH  per-bit J (set) input.
k  input  WIDTH  per-bit K (reset) input.
q  output  WIDTH  registered flop state.
qn  output  WIDTH  bitwise complement of q (combinational from q).

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset:
  - While rst=1, q=RESET_VALUE and qn=~RESET_VALUE, regardless of clk, j and k.
  - Assertion takes effect immediately, not on a clock edge.
  - Reset has priority over a simultaneous clock edge.
- Reset release:
  - On deassertion, q holds RESET_VALUE until the next rising clk edge.
  - The first rising edge with rst=0 applies the normal JK rule.
- Normal operation, per bit i, evaluated on each rising clk edge with rst=0, using j[i] and k[i] sampled at the edge:
  - j=0, k=0: hold, q[i] unchanged.
  - j=0, k=1: reset, q[i] becomes 0.
  - j=1, k=0: set, q[i] becomes 1.
  - j=1, k=1: toggle, q[i] becomes ~q[i].
- Equivalent next-state equation: q_next = (j & ~q) | (~k & q), bitwise.
- Latency: one clock. Inputs sampled at edge n appear on q immediately after edge n; there is no combinational path from j or k to q.
- Bit independence: each bit follows its own j/k; mixed commands across bits in the same cycle are legal.
- Sustained toggle: with j=k=1 held, q alternates every rising edge, i.e. a divide-by-2 of clk per bit.
- Unknown or undriven inputs:
  - An X on j or k may propagate X to q in simulation; no X-suppression is required.
  - If rst is left undriven or tied 0, the block operates without reset and q is undefined until a set or reset command is clocked in.
- Timing: no outputs other than q/qn; no handshake. Inputs must meet setup/hold around the rising clk edge; changes between edges have no effect.

Test Plan:
1. Reset, WIDTH=1: assert rst=1 mid-cycle with j=1, k=0 -> q=0 and qn=1 immediately, held across edges. Release rst; the next edge sets q=1.
2. Reset command: rst=0, j=0, k=1, one rising edge -> q=0, qn=1.
3. Set command: j=1, k=0, one rising edge -> q=1, qn=0.
4. Hold command: from q=1, apply j=0, k=0 for 3 edges -> q stays 1. From q=0, the same hold keeps q at 0.
5. Toggle command: from q=1, apply j=1, k=1 -> q=0 after edge 1, 1 after edge 2, 0 after edge 3. Also check that rst asserted between edges during toggling forces q=0 at once.
6. WIDTH=4, RESET_VALUE=4'b1010: after reset q=1010. Then apply j=0011, k=0101 on one edge -> bit0 toggles, bit1 sets, bit2 resets, bit3 holds, giving q=1011 and qn=0100.
